// File: rtl/sprite_draw_arbiter.sv
// Sprite draw arbiter: shares one sprite draw engine among NUM_REQ requesters.
// A winner is chosen in IDLE (round-robin from rr_ptr, or lowest index when
// SPRITE_ARB_FIXED_PRI_EN is defined), its coordinates are latched and a one-cycle
// eng_plot pulse starts the engine; the arbiter then waits for eng_done to fall
// and rise again before pulsing ack to the owner and returning to IDLE.
// Ports: clk, reset_n (sync, active-low), frame_en (grant window), req/req_x/req_y
// (packed per requester), eng_done (engine idle level) | eng_plot, eng_x, eng_y,
// eng_sel (engine command), grant (one-hot owner), ack (completion pulse), busy.
module sprite_draw_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int COORD_W = 10
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       frame_en,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*COORD_W-1:0] req_x,
    input  logic [NUM_REQ*COORD_W-1:0] req_y,
    input  logic                       eng_done,
    output logic                       eng_plot,
    output logic [COORD_W-1:0]         eng_x,
    output logic [COORD_W-1:0]         eng_y,
    output logic [1:0]                 eng_sel,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_LOW,
        WAIT_DONE,
        ACK
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               load;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   win_idx;
    logic               win_vld;

    // Winner scan: first asserted request at or after rr_ptr, wrapping to 0.
    // With fixed priority rr_ptr is held at 0, so this reduces to lowest index.
    always_comb begin : win_scan
        int               k;
        logic [PTR_W-1:0] kk;
        win_idx = '0;
        win_vld = 1'b0;
        k       = 0;
        kk      = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            k = int'(rr_ptr) + j;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            kk = PTR_W'(k);
            if (!win_vld && req[kk]) begin
                win_vld = 1'b1;
                win_idx = kk;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                // The engine must be idle before we commit to a new grant.
                if (frame_en && win_vld && eng_done) begin
                    load      = 1'b1;
                    state_nxt = START;
                end
            end
            START:     state_nxt = WAIT_LOW;
            WAIT_LOW:  if (!eng_done) state_nxt = WAIT_DONE;
            WAIT_DONE: if (eng_done)  state_nxt = ACK;
            ACK:       state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Owner and coordinates are captured only on the grant decision, so any
    // later change on req/req_x/req_y/frame_en cannot disturb a draw in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr <= '0;
            owner  <= '0;
            grant  <= '0;
            eng_x  <= '0;
            eng_y  <= '0;
        end else if (load) begin
            owner <= win_idx;
            grant <= NUM_REQ'(1) << win_idx;
            eng_x <= req_x[int'(win_idx)*COORD_W +: COORD_W];
            eng_y <= req_y[int'(win_idx)*COORD_W +: COORD_W];
        end else if (state == ACK) begin
            grant <= '0;
            owner <= '0;
`ifdef SPRITE_ARB_FIXED_PRI_EN
            rr_ptr <= '0;
`else
            rr_ptr <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
`endif
        end
    end

    assign eng_plot = (state == START);
    assign ack      = (state == ACK) ? grant : '0;
    assign busy     = (state != IDLE);
    // owner is cleared when returning to IDLE, so eng_sel reads 0 when idle.
    assign eng_sel  = 2'(owner);

endmodule
